// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALU op codes, forward-select encoding
// and default datapath widths.
package id_ex_stage_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RADDR_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding mux for one ALU source: picks EX/MEM, then MEM/WB, then
// the registered register-file value. Register 0 is never forwarded.
module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic [RADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]  regData_i,
  input  logic               exmemRegWrite_i,
  input  logic [RADDR_W-1:0] exmemRdAddr_i,
  input  logic [DATA_W-1:0]  exmemResult_i,
  input  logic               memwbRegWrite_i,
  input  logic [RADDR_W-1:0] memwbRdAddr_i,
  input  logic [DATA_W-1:0]  memwbResult_i,
  output logic [DATA_W-1:0]  fwdData_o
);

  fwd_sel_e sel;
  logic     addrNonZero;

  assign addrNonZero = (addr_i != '0);

  always_comb begin
    sel = FWD_NONE;
    if (exmemRegWrite_i && addrNonZero && (exmemRdAddr_i == addr_i)) begin
      sel = FWD_EXMEM;
    end else if (memwbRegWrite_i && addrNonZero && (memwbRdAddr_i == addr_i)) begin
      sel = FWD_MEMWB;
    end
  end

  always_comb begin
    case (sel)
      FWD_EXMEM: fwdData_o = exmemResult_i;
      FWD_MEMWB: fwdData_o = memwbResult_i;
      default:   fwdData_o = regData_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Forwarding and stall-reload are enabled by defining IDEX_FORWARD_EN.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [RADDR_W-1:0] id_rs_addr,
  input  logic [RADDR_W-1:0] id_rt_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic [3:0]         id_alu_ctrl,
  input  logic               id_alu_src,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               stall,
  input  logic               flush,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd_addr,
  input  logic [DATA_W-1:0]  exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd_addr,
  input  logic [DATA_W-1:0]  memwb_result,
  output logic [DATA_W-1:0]  alu_data1,
  output logic [DATA_W-1:0]  alu_data2,
  output logic [3:0]         alu_ctrl,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic               load_use_hazard
);

  logic               valid_q,    valid_d;
  logic [DATA_W-1:0]  rsData_q,   rsData_d;
  logic [DATA_W-1:0]  rtData_q,   rtData_d;
  logic [DATA_W-1:0]  imm_q,      imm_d;
  logic [RADDR_W-1:0] rsAddr_q,   rsAddr_d;
  logic [RADDR_W-1:0] rtAddr_q,   rtAddr_d;
  logic [RADDR_W-1:0] rdAddr_q,   rdAddr_d;
  logic [3:0]         aluCtrl_q,  aluCtrl_d;
  logic               aluSrc_q,   aluSrc_d;
  logic               regWrite_q, regWrite_d;
  logic               memRead_q,  memRead_d;
  logic               memWrite_q, memWrite_d;
  logic               memToReg_q, memToReg_d;

  logic [DATA_W-1:0]  fwdRs;
  logic [DATA_W-1:0]  fwdRt;

`ifdef IDEX_FORWARD_EN
  fwd_unit #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwdRs (
    .addr_i          (rsAddr_q),
    .regData_i       (rsData_q),
    .exmemRegWrite_i (exmem_reg_write),
    .exmemRdAddr_i   (exmem_rd_addr),
    .exmemResult_i   (exmem_result),
    .memwbRegWrite_i (memwb_reg_write),
    .memwbRdAddr_i   (memwb_rd_addr),
    .memwbResult_i   (memwb_result),
    .fwdData_o       (fwdRs)
  );

  fwd_unit #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwdRt (
    .addr_i          (rtAddr_q),
    .regData_i       (rtData_q),
    .exmemRegWrite_i (exmem_reg_write),
    .exmemRdAddr_i   (exmem_rd_addr),
    .exmemResult_i   (exmem_result),
    .memwbRegWrite_i (memwb_reg_write),
    .memwbRdAddr_i   (memwb_rd_addr),
    .memwbResult_i   (memwb_result),
    .fwdData_o       (fwdRt)
  );
`else
  logic unused_fwd_sources;

  assign fwdRs = rsData_q;
  assign fwdRt = rtData_q;
  assign unused_fwd_sources = ^{exmem_reg_write, exmem_rd_addr, exmem_result,
                                memwb_reg_write, memwb_rd_addr, memwb_result,
                                rsAddr_q, rtAddr_q};
`endif

  // Flush beats stall beats load; a stalled entry re-captures its forwarded
  // operands so a producer retiring during the stall is not lost.
  always_comb begin
    valid_d    = valid_q;
    rsData_d   = rsData_q;
    rtData_d   = rtData_q;
    imm_d      = imm_q;
    rsAddr_d   = rsAddr_q;
    rtAddr_d   = rtAddr_q;
    rdAddr_d   = rdAddr_q;
    aluCtrl_d  = aluCtrl_q;
    aluSrc_d   = aluSrc_q;
    regWrite_d = regWrite_q;
    memRead_d  = memRead_q;
    memWrite_d = memWrite_q;
    memToReg_d = memToReg_q;
    if (flush) begin
      valid_d    = 1'b0;
      rsData_d   = '0;
      rtData_d   = '0;
      imm_d      = '0;
      rsAddr_d   = '0;
      rtAddr_d   = '0;
      rdAddr_d   = '0;
      aluCtrl_d  = ALU_NOP;
      aluSrc_d   = 1'b0;
      regWrite_d = 1'b0;
      memRead_d  = 1'b0;
      memWrite_d = 1'b0;
      memToReg_d = 1'b0;
    end else if (stall) begin
`ifdef IDEX_FORWARD_EN
      rsData_d = fwdRs;
      rtData_d = fwdRt;
`endif
    end else begin
      valid_d    = id_valid;
      rsData_d   = id_rs_data;
      rtData_d   = id_rt_data;
      imm_d      = id_imm;
      rsAddr_d   = id_rs_addr;
      rtAddr_d   = id_rt_addr;
      rdAddr_d   = id_rd_addr;
      aluCtrl_d  = id_alu_ctrl;
      aluSrc_d   = id_alu_src;
      regWrite_d = id_reg_write;
      memRead_d  = id_mem_read;
      memWrite_d = id_mem_write;
      memToReg_d = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rsData_q   <= '0;
      rtData_q   <= '0;
      imm_q      <= '0;
      rsAddr_q   <= '0;
      rtAddr_q   <= '0;
      rdAddr_q   <= '0;
      aluCtrl_q  <= ALU_NOP;
      aluSrc_q   <= 1'b0;
      regWrite_q <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      memToReg_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rsData_q   <= rsData_d;
      rtData_q   <= rtData_d;
      imm_q      <= imm_d;
      rsAddr_q   <= rsAddr_d;
      rtAddr_q   <= rtAddr_d;
      rdAddr_q   <= rdAddr_d;
      aluCtrl_q  <= aluCtrl_d;
      aluSrc_q   <= aluSrc_d;
      regWrite_q <= regWrite_d;
      memRead_q  <= memRead_d;
      memWrite_q <= memWrite_d;
      memToReg_q <= memToReg_d;
    end
  end

  assign alu_data1     = fwdRs;
  assign alu_data2     = aluSrc_q ? imm_q : fwdRt;
  assign ex_store_data = fwdRt;
  assign alu_ctrl      = aluCtrl_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = regWrite_q;
  assign ex_mem_read   = memRead_q;
  assign ex_mem_write  = memWrite_q;
  assign ex_mem_to_reg = memToReg_q;
  assign ex_rd_addr    = rdAddr_q;

  assign load_use_hazard = valid_q && memRead_q && (rdAddr_q != '0) && id_valid &&
                           ((id_rs_addr == rdAddr_q) || (id_rt_addr == rdAddr_q));

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-forwarding stage of the 5-stage MIPS core. It captures decoded operands and control from ID, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU's data1/data2/ctrl inputs directly. It also flags load-use hazards back to the hazard/stall logic, and supports stall (hold) and flush (bubble) from the pipeline controller.

## Interface
- DATA_W, 32, datapath width
- RADDR_W, 5, register-file address width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs_addr, id_rt_addr, id_rd_addr  in  RADDR_W  source/destination registers
- id_alu_ctrl  in  4  ALU operation code
- id_alu_src  in  1  1 = data2 from immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
- stall  in  1  hold ID/EX contents
- flush  in  1  insert bubble
- exmem_reg_write  in  1; exmem_rd_addr  in  RADDR_W; exmem_result  in  DATA_W  EX/MEM forward source
- memwb_reg_write  in  1; memwb_rd_addr  in  RADDR_W; memwb_result  in  DATA_W  MEM/WB forward source
- alu_data1, alu_data2  out  DATA_W  ALU operands
- alu_ctrl  out  4  ALU operation
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each
- ex_rd_addr  out  RADDR_W
- ex_store_data  out  DATA_W  forwarded rt value for stores
- load_use_hazard  out  1  combinational, to stall logic

## Operation
- Registered fields: valid, rs/rt data, imm, rs/rt/rd addr, alu_ctrl, alu_src, four control bits.
- Update priority each edge: flush > stall > load. Flush: valid, reg_write, mem_read, mem_write, mem_to_reg = 0, alu_ctrl = 4'b1111 (NOP), data/addr = 0. Load: capture all id_* fields.
- Stall: control/addr/imm held; rs/rt data registers reload with their current forwarded values, so a producer draining past MEM/WB during a multi-cycle stall is not lost.
- Forwarding per operand (rs, rt), combinational from registered addr: EX/MEM if exmem_reg_write and exmem_rd_addr == addr and addr != 0; else MEM/WB under same rule; else registered data. EX/MEM wins when both match. Register 0 never forwarded.
- alu_data1 = fwd_rs; alu_data2 = alu_src ? imm : fwd_rt; ex_store_data = fwd_rt always.
- load_use_hazard = ex_valid & ex_mem_read & ex_rd_addr != 0 & id_valid & (id_rs_addr == ex_rd_addr | id_rt_addr == ex_rd_addr).
- When ex_valid = 0, outputs still follow the rules above; alu_ctrl = NOP guarantees no side effect.

## Timing
- Latency: ID inputs visible on ex_*/alu_* 1 cycle after the loading edge; forwarding adds no cycles.
- rst_n low: immediately (asynchronously) all registers to flush values; alu_ctrl = 4'b1111, every other output 0 (forwarding outputs 0 while forward sources inactive). Reset mid-stall discards the held instruction.
- stall and flush together: flush wins. Back-to-back stalls hold indefinitely.
- load_use_hazard has no registered delay; same-cycle path to stall logic.

## Configuration
- IDEX_FORWARD_EN defined: forwarding and stall-reload as above.
- Undefined: alu_data1/alu_data2/ex_store_data use registered data only; exmem_*/memwb_* ignored; stall holds data unchanged; load_use_hazard still generated.

## Structure
- Shared package: ALU control codes (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, XOR 1100, NOP 1111), forward-select encoding (FWD_NONE, FWD_EXMEM, FWD_MEMWB), DATA_W/RADDR_W defaults.
- One sub-module: fwd_unit (combinational select for one operand), instantiated twice.

## Test plan
- Reset: rst_n low mid-run -> alu_ctrl = 4'b1111, ex_valid = 0, alu_data1/2 = 0 without a clock edge.
- EX/MEM forward: load rs=8, id_rs_data=5; exmem_reg_write=1, rd=8, result=0x64 -> alu_data1 = 0x64.
- Priority: rt=9 matches both exmem (0xAA) and memwb (0xBB) -> alu_data2 = 0xAA; rt=0 with matches -> registered data.
- Immediate: id_alu_src=1, id_imm=0xFFFFFFFC -> alu_data2 = 0xFFFFFFFC, ex_store_data = forwarded rt.
- Load-use: EX holds lw to r3, ID reads r3 -> load_use_hazard = 1; stall 2 cycles with memwb rd=3 result=0x10 in cycle 1 -> after release, alu_data1 = 0x10.
- stall=1, flush=1 same edge -> bubble (ex_valid = 0, alu_ctrl = 4'b1111).
